// File: rtl/dmem_arbiter_if.sv
// Bundle for the data-memory arbiter: CPU port, debug/loader port and the byte-wide memory port.
// slave = the arbiter's view, master = the requesters' and memory's view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [1:0]        cpu_size;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_done;
  logic              cpu_err;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_wdata;
  logic [31:0]       dbg_rdata;
  logic              dbg_done;
  logic              dbg_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_size, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_err, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_done, dbg_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_size, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_err, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_done, dbg_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU, debug) arbiter onto a byte-wide data memory; accesses are serialised byte by byte.
// Define DMEM_ARB_DBG_PRIO_EN to give debug fixed priority instead of round-robin.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int         CW     = ADDR_W + 1;

  logic [1:0]        state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [1:0]        last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              src_dbg_q, src_dbg_d;
  logic              err_q, err_d;
  logic              rr_dbg_q, rr_dbg_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       dbg_rdata_q, dbg_rdata_d;

  logic              grant_dbg;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [1:0]        sel_last;
  logic [ADDR_W:0]   sel_end;
  logic              sel_oob;

  logic [3:0][7:0]   wr_lane;
  logic [3:0][7:0]   rd_lane;
  logic [31:0]       xfer_acc;

`ifdef DMEM_ARB_DBG_PRIO_EN
  assign grant_dbg = bus.dbg_req;
`else
  // rr_dbg_q is set after every CPU grant, so a contested request alternates.
  assign grant_dbg = bus.dbg_req && (!bus.cpu_req || rr_dbg_q);
`endif

  assign sel_we    = grant_dbg ? bus.dbg_we    : bus.cpu_we;
  assign sel_addr  = grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
  assign sel_wdata = grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;

  always_comb begin
    sel_last = 2'd3;
    if (!grant_dbg) begin
      case (bus.cpu_size)
        2'b00:   sel_last = 2'd0;
        2'b01:   sel_last = 2'd1;
        default: sel_last = 2'd3;
      endcase
    end
  end

  // Extra top bit so an access straddling the end of the address space still counts as out of range.
  assign sel_end = {1'b0, sel_addr} + {{(ADDR_W-1){1'b0}}, sel_last};
  assign sel_oob = sel_end >= CW'(MEM_BYTES);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wr_lane[gi] = wdata_q[8*gi +: 8];
    assign rd_lane[gi] = (!we_q && (k_q == 2'(gi))) ? bus.mem_rdata : acc_q[8*gi +: 8];
  end
  assign xfer_acc = rd_lane;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    src_dbg_d   = src_dbg_q;
    err_d       = err_q;
    rr_dbg_d    = rr_dbg_q;
    acc_d       = acc_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req || bus.dbg_req) begin
          src_dbg_d = grant_dbg;
          rr_dbg_d  = !grant_dbg;
          we_d      = sel_we;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          last_d    = sel_last;
          k_d       = 2'd0;
          acc_d     = 32'd0;
          err_d     = sel_oob;
          if (sel_oob) begin
            state_d = S_DONE;
            if (grant_dbg) dbg_rdata_d = 32'd0;
            else           cpu_rdata_d = 32'd0;
          end else begin
            state_d = S_XFER;
          end
        end
      end
      S_XFER: begin
        acc_d = xfer_acc;
        if (k_q == last_q) begin
          state_d = S_DONE;
          k_d     = 2'd0;
          if (src_dbg_q) dbg_rdata_d = xfer_acc;
          else           cpu_rdata_d = xfer_acc;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_q         <= 2'd0;
      last_q      <= 2'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      src_dbg_q   <= 1'b0;
      err_q       <= 1'b0;
      rr_dbg_q    <= 1'b0;
      acc_q       <= 32'd0;
      cpu_rdata_q <= 32'd0;
      dbg_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      src_dbg_q   <= src_dbg_d;
      err_q       <= err_d;
      rr_dbg_q    <= rr_dbg_d;
      acc_q       <= acc_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Memory strobes decode straight from state so an asynchronous reset drops them at once.
  assign bus.mem_en    = (state_q == S_XFER);
  assign bus.mem_we    = (state_q == S_XFER) && we_q;
  assign bus.mem_addr  = addr_q + ADDR_W'(k_q);
  assign bus.mem_wdata = wr_lane[k_q];

  assign bus.cpu_done  = (state_q == S_DONE) && !src_dbg_q;
  assign bus.dbg_done  = (state_q == S_DONE) && src_dbg_q;
  assign bus.cpu_err   = bus.cpu_done && err_q;
  assign bus.dbg_err   = bus.dbg_done && err_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.cpu_stall = bus.cpu_req && !bus.cpu_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then random traffic
// checked each cycle against a transaction-level schedule model.
module tb_dmem_arbiter;
  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 1024;
`ifdef DMEM_ARB_DBG_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus_if ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  logic [7:0] mem     [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  assign bus_if.mem_rdata = (bus_if.mem_addr < 32'(MEM_BYTES)) ? mem[bus_if.mem_addr[9:0]] : 8'h00;
  always @(posedge clk)
    if (bus_if.mem_en && bus_if.mem_we && bus_if.mem_addr < 32'(MEM_BYTES))
      mem[bus_if.mem_addr[9:0]] <= bus_if.mem_wdata;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural model: one expected record per cycle after a grant
  typedef struct {
    bit          en;
    bit          we;
    logic [31:0] addr;
    logic [7:0]  wb;
    bit          cd;
    bit          dd;
    bit          err;
    logic [31:0] rdata;
    bit          rchk;
  } rec_t;

  rec_t        sched[$];
  rec_t        cur;
  bit          rr_dbg;
  logic [31:0] exp_cpu_rdata, exp_dbg_rdata;
  bit          cpu_rchk, dbg_rchk;
  bit          ecd, edd, eerr;

  task automatic plan_txn();
    bit          g_dbg;
    int          n;
    logic [31:0] a, wd, rd;
    bit          w;
    rec_t        r;
    if (bus_if.cpu_req && bus_if.dbg_req) g_dbg = PRIO ? 1'b1 : rr_dbg;
    else                                  g_dbg = bus_if.dbg_req;
    rr_dbg = !g_dbg;
    if (g_dbg)                        n = 4;
    else if (bus_if.cpu_size == 2'b00) n = 1;
    else if (bus_if.cpu_size == 2'b01) n = 2;
    else                              n = 4;
    a  = g_dbg ? bus_if.dbg_addr  : bus_if.cpu_addr;
    w  = g_dbg ? bus_if.dbg_we    : bus_if.cpu_we;
    wd = g_dbg ? bus_if.dbg_wdata : bus_if.cpu_wdata;
    r = '{default: 0};
    if (longint'(a) + n > MEM_BYTES) begin
      r.cd = !g_dbg; r.dd = g_dbg; r.err = 1'b1; r.rdata = 32'd0; r.rchk = 1'b1;
      sched.push_back(r);
    end else begin
      rd = 32'd0;
      for (int k = 0; k < n; k++) begin
        r = '{default: 0};
        r.en = 1'b1; r.we = w; r.addr = a + 32'(k); r.wb = 8'(wd >> (8*k));
        sched.push_back(r);
        if (!w) rd = rd | (32'(ref_mem[r.addr[9:0]]) << (8*k));
      end
      r = '{default: 0};
      r.cd = !g_dbg; r.dd = g_dbg; r.rdata = rd; r.rchk = !w;
      sched.push_back(r);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      sched.delete();
      rr_dbg = 1'b0;
      exp_cpu_rdata = 32'd0; exp_dbg_rdata = 32'd0;
      cpu_rchk = 1'b1; dbg_rchk = 1'b1;
      chk("rst_mem_en", bus_if.mem_en, 0);
      chk("rst_mem_we", bus_if.mem_we, 0);
      chk("rst_cpu_done", bus_if.cpu_done, 0);
      chk("rst_dbg_done", bus_if.dbg_done, 0);
      chk("rst_cpu_err", bus_if.cpu_err, 0);
      chk("rst_dbg_err", bus_if.dbg_err, 0);
      chk("rst_cpu_rdata", bus_if.cpu_rdata, 0);
      chk("rst_dbg_rdata", bus_if.dbg_rdata, 0);
      chk("rst_cpu_stall", bus_if.cpu_stall, bus_if.cpu_req);
    end else begin
      ecd = 1'b0; edd = 1'b0; eerr = 1'b0;
      if (sched.size() > 0) begin
        cur = sched.pop_front();
        chk("mem_en", bus_if.mem_en, cur.en);
        chk("mem_we", bus_if.mem_we, cur.we);
        if (cur.en) begin
          chk("mem_addr", bus_if.mem_addr, cur.addr);
          if (cur.we) begin
            chk("mem_wdata", bus_if.mem_wdata, cur.wb);
            ref_mem[cur.addr[9:0]] = cur.wb;
          end
        end
        ecd = cur.cd; edd = cur.dd; eerr = cur.err;
        if (cur.cd) begin exp_cpu_rdata = cur.rdata; cpu_rchk = cur.rchk; end
        if (cur.dd) begin exp_dbg_rdata = cur.rdata; dbg_rchk = cur.rchk; end
      end else begin
        chk("idle_mem_en", bus_if.mem_en, 0);
        chk("idle_mem_we", bus_if.mem_we, 0);
        if (bus_if.cpu_req || bus_if.dbg_req) plan_txn();
      end
      chk("cpu_done", bus_if.cpu_done, ecd);
      chk("dbg_done", bus_if.dbg_done, edd);
      chk("cpu_err", bus_if.cpu_err, ecd & eerr);
      chk("dbg_err", bus_if.dbg_err, edd & eerr);
      chk("cpu_stall", bus_if.cpu_stall, bus_if.cpu_req & !ecd);
      if (cpu_rchk) chk("cpu_rdata", bus_if.cpu_rdata, exp_cpu_rdata);
      if (dbg_rchk) chk("dbg_rdata", bus_if.dbg_rdata, exp_dbg_rdata);
    end
  end

  // ---------------- stimulus helpers
  task automatic cpu_drive(input bit req, input bit we, input logic [31:0] addr,
                           input logic [1:0] size, input logic [31:0] wd);
    bus_if.cpu_req = req; bus_if.cpu_we = we; bus_if.cpu_addr = addr;
    bus_if.cpu_size = size; bus_if.cpu_wdata = wd;
  endtask

  task automatic dbg_drive(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    bus_if.dbg_req = req; bus_if.dbg_we = we; bus_if.dbg_addr = addr; bus_if.dbg_wdata = wd;
  endtask

  task automatic wait_done(input bit want_dbg, input int start, output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (want_dbg ? bus_if.dbg_done : bus_if.cpu_done) begin
        lat = cyc - start;
        return;
      end
    end
    chk("done_timeout", 0, 1);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 32'(MEM_BYTES - 4 + int'($urandom_range(0, 7)));
    return 32'($urandom_range(0, MEM_BYTES - 1));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int lat, t0, g, bad;
  bit cd, dd, cpu_act, dbg_act;

  initial begin
    cpu_drive(0, 0, 0, 0, 0);
    dbg_drive(0, 0, 0, 0);
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // CPU word write 0x200 <- 9
    cpu_drive(1, 1, 32'h200, 2'b10, 32'h0000_0009); t0 = cyc;
    wait_done(0, t0, lat);
    chk("w_word_latency", 32'(lat), 5);
    chk("w_word_mem", {mem[32'h203], mem[32'h202], mem[32'h201], mem[32'h200]}, 32'h0000_0009);
    @(posedge clk); #1 cpu_drive(0, 0, 0, 0, 0);

    // CPU half read 0x204 with bytes 34,12
    mem[32'h204] = 8'h34; ref_mem[32'h204] = 8'h34;
    mem[32'h205] = 8'h12; ref_mem[32'h205] = 8'h12;
    @(posedge clk); #1 cpu_drive(1, 0, 32'h204, 2'b01, 0); t0 = cyc;
    wait_done(0, t0, lat);
    chk("r_half_latency", 32'(lat), 3);
    chk("r_half_rdata", bus_if.cpu_rdata, 32'h0000_1234);
    @(posedge clk); #1 cpu_drive(0, 0, 0, 0, 0);

    // Debug word read past the end
    @(posedge clk); #1 dbg_drive(1, 0, 32'h3FE, 0); t0 = cyc;
    wait_done(1, t0, lat);
    chk("oob_latency", 32'(lat), 1);
    chk("oob_err", bus_if.dbg_err, 1);
    chk("oob_rdata", bus_if.dbg_rdata, 0);
    @(posedge clk); #1 dbg_drive(0, 0, 0, 0);

    // Contested requests straight out of reset
    rst = 1'b0;
    cpu_drive(1, 0, 32'h10, 2'b00, 0);
    dbg_drive(1, 0, 32'h20, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      g = -1;
      for (int w = 0; w < 20 && g < 0; w++) begin
        @(negedge clk);
        if (bus_if.cpu_done) g = 0;
        else if (bus_if.dbg_done) g = 1;
      end
      chk("rr_grant", 32'(g), PRIO ? 32'd1 : 32'(i % 2));
      @(posedge clk); #1;
    end
    cpu_drive(0, 0, 0, 0, 0); dbg_drive(0, 0, 0, 0);

    // Reset in the second XFER cycle of a word write
    for (int i = 0; i < 4; i++) begin mem[32'h300 + i] = 8'hAA; ref_mem[32'h300 + i] = 8'hAA; end
    @(posedge clk); #1 cpu_drive(1, 1, 32'h300, 2'b10, 32'h1122_3344);
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;
    #1;
    chk("abort_mem_en", bus_if.mem_en, 0);
    chk("abort_mem_we", bus_if.mem_we, 0);
    cpu_drive(0, 0, 0, 0, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_mem", {mem[32'h303], mem[32'h302], mem[32'h301], mem[32'h300]}, 32'hAAAA_AA44);

    // Back-to-back CPU byte writes with req held
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      cpu_drive(1, 1, 32'h200 + 32'(i), 2'b00, 32'h50 + 32'(i)); t0 = cyc;
      wait_done(0, t0, lat);
      chk("b2b_latency", 32'(lat), 2);
      @(posedge clk); #1;
    end
    cpu_drive(0, 0, 0, 0, 0);
    chk("b2b_mem", {mem[32'h209], mem[32'h200]}, 32'h5950);

    // Random traffic
    cpu_act = 1'b0; dbg_act = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      cd = bus_if.cpu_done; dd = bus_if.dbg_done;
      @(posedge clk); #1;
      if (!cpu_act || cd) begin
        cpu_act = ($urandom_range(0, 3) != 0);
        cpu_drive(cpu_act, 1'($urandom_range(0, 1)), rand_addr(), 2'($urandom_range(0, 3)), $urandom);
      end
      if (!dbg_act || dd) begin
        dbg_act = ($urandom_range(0, 3) != 0);
        dbg_drive(dbg_act, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end
    end
    // Let the last transaction drain before comparing memory images.
    for (int w = 0; w < 20 && (cpu_act || dbg_act); w++) begin
      @(negedge clk);
      cd = bus_if.cpu_done; dd = bus_if.dbg_done;
      @(posedge clk); #1;
      if (cd) begin cpu_act = 1'b0; cpu_drive(0, 0, 0, 0, 0); end
      if (dd) begin dbg_act = 1'b0; dbg_drive(0, 0, 0, 0); end
    end
    cpu_drive(0, 0, 0, 0, 0); dbg_drive(0, 0, 0, 0);
    repeat (10) @(posedge clk);
    bad = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", 32'(bad), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of all address ports.
REQ-002 SHALL have parameter MEM_BYTES, default 1024, number of addressable data-memory bytes.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have ports cpu_req/cpu_we  input  1/1  CPU MEM-stage access request and write enable.
REQ-006 SHALL have ports cpu_addr  input  ADDR_W, cpu_size  input  2 (00 byte, 01 half, 10/11 word), cpu_wdata  input  32.
REQ-007 SHALL have ports cpu_rdata  output  32, cpu_done  output  1, cpu_err  output  1, cpu_stall  output  1.
REQ-008 SHALL have ports dbg_req/dbg_we  input  1/1, dbg_addr  input  ADDR_W, dbg_wdata  input  32, each debug/loader access a full word.
REQ-009 SHALL have ports dbg_rdata  output  32, dbg_done  output  1, dbg_err  output  1.
REQ-010 SHALL have ports mem_en/mem_we  output  1/1, mem_addr  output  ADDR_W, mem_wdata  output  8, mem_rdata  input  8 (combinational byte read).

Function
REQ-011 SHALL implement FSM IDLE -> XFER -> DONE -> IDLE.
REQ-012 In IDLE, SHALL sample the req lines and, if any is high, latch the winner's we/addr/size/wdata and enter XFER on the next edge.
REQ-013 Both requests high in IDLE: SHALL grant the requester that did not win the previous grant (round-robin); first grant after reset goes to CPU.
REQ-014 Byte count N SHALL be 1/2/4 for cpu_size 00/01/1x and 4 for debug.
REQ-015 XFER SHALL last exactly N cycles, byte counter k = 0..N-1, driving mem_en=1 and mem_addr=addr+k.
REQ-016 Writes SHALL drive mem_we=1 and mem_wdata=wdata[8k+7:8k] (little-endian).
REQ-017 Reads SHALL capture mem_rdata into rdata[8k+7:8k]; unused upper bytes SHALL be zero (no sign extension).
REQ-018 If addr+N-1 >= MEM_BYTES, SHALL skip XFER (no mem_en), go directly to DONE and assert *_err with *_done; rdata=0.
REQ-019 DONE SHALL last one cycle, pulsing the granted requester's *_done; *_err valid only alongside *_done.
REQ-020 Latency: request sampled at edge T -> *_done high during cycle T+N+1 (T+1 on error).
REQ-021 *_rdata SHALL hold its value from DONE until that requester's next DONE.
REQ-022 cpu_stall SHALL equal cpu_req AND NOT cpu_done (combinational).
REQ-023 mem_en, mem_we SHALL be 0 outside XFER; mem_addr/mem_wdata don't-care when mem_en=0.
REQ-024 Requesters SHALL hold req and fields stable until *_done; a request still high in the cycle after DONE is treated as a new request.
REQ-025 Requests arriving during XFER/DONE SHALL be ignored until IDLE; nothing is queued.

Reset
REQ-026 rst=0 SHALL immediately force IDLE, k=0, all outputs 0 (rdata=0, done=0, err=0, mem_en=0, mem_we=0), and the round-robin pointer to "CPU next".
REQ-027 Reset during XFER SHALL abort with no further mem_we; bytes already written remain in memory.

Configuration
REQ-028 With macro DMEM_ARB_DBG_PRIO_EN defined, simultaneous requests SHALL always grant debug (fixed priority); without it, round-robin per REQ-013 applies.

Verification
REQ-029 CPU word write addr 0x200 data 0x0000_0009 -> mem writes 0x09,00,00,00 at 0x200..0x203 in 4 consecutive cycles, cpu_done at T+5, cpu_stall high T..T+4.
REQ-030 CPU half read addr 0x204, memory bytes 0x34,0x12 -> cpu_rdata=0x0000_1234, 2 XFER cycles, done at T+3.
REQ-031 cpu_req and dbg_req high together from reset, both held -> grants CPU, DBG, CPU (macro off); DBG, DBG, ... with macro on and CPU held waiting.
REQ-032 Debug word read addr 0x3FE (MEM_BYTES=1024) -> no mem_en, dbg_done and dbg_err high at T+1, dbg_rdata=0.
REQ-033 rst pulled low in 2nd XFER cycle of word write -> mem_en/mem_we drop asynchronously, FSM IDLE, only byte 0 written, no done pulse.
REQ-034 Back-to-back CPU byte writes 0x200..0x209 with req held -> each done 2 cycles after acceptance, one idle sampling cycle between transactions.
